sram_like_arb2: RTL and testbench

Two-master arbiter sitting directly downstream of the CPU core's sram-like ports: merges the instruction fetch port (read-only) and the data port onto one sram-like port toward the memory bridge. An in-order owner FIFO tracks up to `MAX_OUTST` accepted-but-unanswered requests and routes each returning `data_ok`/`rdata` to the master that issued it.

---
 rtl/sram_like_arb2.sv | 133 +++++++++++++
 tb/tb_sram_like_arb2.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arb2.sv
// sram_like_arb2: merges inst fetch and data sram-like ports onto one out port.
// Optional macro SRAM_ARB_RR_EN: round-robin grant under contention.
module sram_like_arb2 #(
    parameter int MAX_OUTST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTST);

    logic [MAX_OUTST-1:0] own_q;
    logic [PW-1:0]        wptr;
    logic [PW-1:0]        rptr;
    logic [CW-1:0]        cnt;
    logic                 lock_v;
    logic                 lock_own;
    logic                 full;
    logic                 grant;
    logic                 push;
    logic                 pop;
    logic                 rd_own;

`ifdef SRAM_ARB_RR_EN
    logic last;

    // last=0 means inst won most recently, so data goes first after reset
    always_comb begin
        if (lock_v)
            grant = lock_own;
        else if (data_sram_req && inst_sram_req)
            grant = ~last;
        else
            grant = data_sram_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= 1'b0;
        else if (push)
            last <= grant;
    end
`else
    always_comb begin
        grant = lock_v ? lock_own : data_sram_req;
    end
`endif

    assign full = (cnt == CNT_FULL);

    always_comb begin
        out_req = (grant ? data_sram_req : inst_sram_req) & ~full;
        if (grant) begin
            out_wr    = data_sram_wr;
            out_size  = data_sram_size;
            out_wstrb = data_sram_wstrb;
            out_addr  = data_sram_addr;
            out_wdata = data_sram_wdata;
        end else begin
            out_wr    = 1'b0;
            out_size  = 2'b10;
            out_wstrb = 4'b0000;
            out_addr  = inst_sram_addr;
            out_wdata = 32'h0;
        end
    end

    assign push   = out_req & out_addr_ok;
    assign pop    = out_data_ok & (cnt != '0);
    assign rd_own = own_q[rptr];

    assign inst_sram_addr_ok = push & ~grant;
    assign data_sram_addr_ok = push & grant;

    // stray responses with nothing outstanding fall through pop=0
    assign inst_sram_data_ok = pop & ~rd_own;
    assign data_sram_data_ok = pop & rd_own;
    assign inst_sram_rdata   = out_rdata;
    assign data_sram_rdata   = out_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own_q    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            lock_v   <= 1'b0;
            lock_own <= 1'b0;
        end else begin
            if (push) begin
                own_q[wptr] <= grant;
                wptr        <= wptr + PW'(1);
            end
            if (pop)
                rptr <= rptr + PW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
            // hold the presented request stable until the slave takes it
            if (out_req && !out_addr_ok) begin
                lock_v   <= 1'b1;
                lock_own <= grant;
            end else if (push) begin
                lock_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sram_like_arb2.sv
// tb_sram_like_arb2: directed bench for sram_like_arb2 (MAX_OUTST=4).
// Expected grants follow SRAM_ARB_RR_EN when it is defined.
module tb_sram_like_arb2;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        out_req;
    logic        out_wr;
    logic [1:0]  out_size;
    logic [3:0]  out_wstrb;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic        out_addr_ok;
    logic        out_data_ok;
    logic [31:0] out_rdata;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sram_like_arb2 #(.MAX_OUTST(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .out_req           (out_req),
        .out_wr            (out_wr),
        .out_size          (out_size),
        .out_wstrb         (out_wstrb),
        .out_addr          (out_addr),
        .out_wdata         (out_wdata),
        .out_addr_ok       (out_addr_ok),
        .out_data_ok       (out_data_ok),
        .out_rdata         (out_rdata)
    );

    task automatic idle();
        inst_sram_req   = 1'b0;
        inst_sram_addr  = 32'h0;
        data_sram_req   = 1'b0;
        data_sram_wr    = 1'b0;
        data_sram_size  = 2'b00;
        data_sram_wstrb = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        out_addr_ok     = 1'b0;
        out_data_ok     = 1'b0;
        out_rdata       = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        out_data_ok = 1'b1;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL reset_data_ok: got %b%b want 00", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        reset = 1'b0;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL reset_stray: got %b%b want 00", inst_sram_data_ok, data_sram_data_ok);
        end
        out_data_ok = 1'b0;
        #1;
        nvec++;
        if (out_req !== 1'b0) begin
            nerr++;
            $display("FAIL reset_out_req: got %b want 0", out_req);
        end
        step();
    endtask

    task automatic test_single_fetch();
        do_reset();
        step();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hBFC00000;
        out_addr_ok    = 1'b1;
        #1;
        nvec++;
        if (out_req !== 1'b1 || out_addr !== 32'hBFC00000) begin
            nerr++;
            $display("FAIL fetch_out: got req=%b addr=%h want 1 bfc00000", out_req, out_addr);
        end
        nvec++;
        if (out_wr !== 1'b0 || out_size !== 2'b10 || out_wstrb !== 4'h0 || out_wdata !== 32'h0) begin
            nerr++;
            $display("FAIL fetch_attr: got wr=%b size=%b wstrb=%h wdata=%h want 0 10 0 0",
                     out_wr, out_size, out_wstrb, out_wdata);
        end
        nvec++;
        if (inst_sram_addr_ok !== 1'b1 || data_sram_addr_ok !== 1'b0) begin
            nerr++;
            $display("FAIL fetch_addr_ok: got %b%b want 10", inst_sram_addr_ok, data_sram_addr_ok);
        end
        step();
        idle();
        out_data_ok = 1'b1;
        out_rdata   = 32'h3C080001;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL fetch_data_ok: got %b%b want 10", inst_sram_data_ok, data_sram_data_ok);
        end
        nvec++;
        if (inst_sram_rdata !== 32'h3C080001) begin
            nerr++;
            $display("FAIL fetch_rdata: got %h want 3c080001", inst_sram_rdata);
        end
        step();
        idle();
    endtask

    task automatic test_contention();
        logic [2:0] exp_own;
`ifdef SRAM_ARB_RR_EN
        exp_own = 3'b101;
`else
        exp_own = 3'b011;
`endif
        do_reset();
        step();
        inst_sram_req   = 1'b1;
        inst_sram_addr  = 32'hBFC00004;
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'b10;
        data_sram_wstrb = 4'hF;
        data_sram_addr  = 32'h00001000;
        data_sram_wdata = 32'hDEADBEEF;
        out_addr_ok     = 1'b1;
        #1;
        nvec++;
        if (data_sram_addr_ok !== 1'b1 || inst_sram_addr_ok !== 1'b0) begin
            nerr++;
            $display("FAIL cont1_grant: got d=%b i=%b want 1 0", data_sram_addr_ok, inst_sram_addr_ok);
        end
        nvec++;
        if (out_addr !== 32'h00001000 || out_wr !== 1'b1 || out_wdata !== 32'hDEADBEEF) begin
            nerr++;
            $display("FAIL cont1_out: got addr=%h wr=%b wdata=%h want 00001000 1 deadbeef",
                     out_addr, out_wr, out_wdata);
        end
        step();
        data_sram_wr    = 1'b0;
        data_sram_wstrb = 4'h0;
        data_sram_addr  = 32'h00001004;
        #1;
`ifdef SRAM_ARB_RR_EN
        nvec++;
        if (inst_sram_addr_ok !== 1'b1 || out_addr !== 32'hBFC00004) begin
            nerr++;
            $display("FAIL cont2_rr: got i=%b addr=%h want 1 bfc00004", inst_sram_addr_ok, out_addr);
        end
        step();
        inst_sram_req = 1'b0;
        #1;
        nvec++;
        if (data_sram_addr_ok !== 1'b1 || out_addr !== 32'h00001004) begin
            nerr++;
            $display("FAIL cont3_rr: got d=%b addr=%h want 1 00001004", data_sram_addr_ok, out_addr);
        end
`else
        nvec++;
        if (data_sram_addr_ok !== 1'b1 || out_addr !== 32'h00001004) begin
            nerr++;
            $display("FAIL cont2_fixed: got d=%b addr=%h want 1 00001004", data_sram_addr_ok, out_addr);
        end
        step();
        data_sram_req = 1'b0;
        #1;
        nvec++;
        if (inst_sram_addr_ok !== 1'b1 || out_addr !== 32'hBFC00004) begin
            nerr++;
            $display("FAIL cont3_fixed: got i=%b addr=%h want 1 bfc00004", inst_sram_addr_ok, out_addr);
        end
`endif
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            out_data_ok = 1'b1;
            out_rdata   = 32'h100 + i;
            #1;
            nvec++;
            if (data_sram_data_ok !== exp_own[i] || inst_sram_data_ok !== ~exp_own[i]) begin
                nerr++;
                $display("FAIL cont_resp%0d: got d=%b i=%b want d=%b", i,
                         data_sram_data_ok, inst_sram_data_ok, exp_own[i]);
            end
            step();
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        step();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hBFC00010;
        #1;
        nvec++;
        if (out_req !== 1'b1 || out_addr !== 32'hBFC00010 || inst_sram_addr_ok !== 1'b0) begin
            nerr++;
            $display("FAIL lock_c0: got req=%b addr=%h ok=%b want 1 bfc00010 0",
                     out_req, out_addr, inst_sram_addr_ok);
        end
        step();
        data_sram_req  = 1'b1;
        data_sram_addr = 32'h00002000;
        data_sram_size = 2'b10;
        for (int c = 1; c < 3; c++) begin
            #1;
            nvec++;
            if (out_addr !== 32'hBFC00010 || out_wr !== 1'b0 || data_sram_addr_ok !== 1'b0) begin
                nerr++;
                $display("FAIL lock_c%0d: got addr=%h wr=%b dok=%b want bfc00010 0 0",
                         c, out_addr, out_wr, data_sram_addr_ok);
            end
            step();
        end
        out_addr_ok = 1'b1;
        #1;
        nvec++;
        if (inst_sram_addr_ok !== 1'b1 || out_addr !== 32'hBFC00010) begin
            nerr++;
            $display("FAIL lock_accept: got ok=%b addr=%h want 1 bfc00010", inst_sram_addr_ok, out_addr);
        end
        step();
        inst_sram_req = 1'b0;
        #1;
        nvec++;
        if (data_sram_addr_ok !== 1'b1 || out_addr !== 32'h00002000) begin
            nerr++;
            $display("FAIL lock_next: got ok=%b addr=%h want 1 00002000", data_sram_addr_ok, out_addr);
        end
        step();
        idle();
        out_data_ok = 1'b1;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL lock_resp0: got %b%b want 10", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b1) begin
            nerr++;
            $display("FAIL lock_resp1: got %b%b want 01", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        idle();
    endtask

    task automatic test_full();
        do_reset();
        step();
        inst_sram_req = 1'b1;
        out_addr_ok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inst_sram_addr = 32'hBFC00100 + 32'(4 * i);
            #1;
            nvec++;
            if (inst_sram_addr_ok !== 1'b1) begin
                nerr++;
                $display("FAIL full_fill%0d: got %b want 1", i, inst_sram_addr_ok);
            end
            step();
        end
        inst_sram_addr = 32'hBFC00110;
        #1;
        nvec++;
        if (out_req !== 1'b0 || inst_sram_addr_ok !== 1'b0) begin
            nerr++;
            $display("FAIL full_block: got req=%b ok=%b want 0 0", out_req, inst_sram_addr_ok);
        end
        step();
        out_data_ok = 1'b1;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b1 || out_req !== 1'b0) begin
            nerr++;
            $display("FAIL full_pop: got dok=%b req=%b want 1 0", inst_sram_data_ok, out_req);
        end
        step();
        out_data_ok = 1'b0;
        #1;
        nvec++;
        if (out_req !== 1'b1 || inst_sram_addr_ok !== 1'b1 || out_addr !== 32'hBFC00110) begin
            nerr++;
            $display("FAIL full_reissue: got req=%b ok=%b addr=%h want 1 1 bfc00110",
                     out_req, inst_sram_addr_ok, out_addr);
        end
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            out_data_ok = 1'b1;
            #1;
            nvec++;
            if (inst_sram_data_ok !== 1'b1) begin
                nerr++;
                $display("FAIL full_drain%0d: got %b want 1", i, inst_sram_data_ok);
            end
            step();
        end
        idle();
    endtask

    task automatic test_ordering();
        do_reset();
        step();
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hBFC00200;
        out_addr_ok    = 1'b1;
        #1;
        nvec++;
        if (inst_sram_addr_ok !== 1'b1) begin
            nerr++;
            $display("FAIL ord_acc0: got %b want 1", inst_sram_addr_ok);
        end
        step();
        inst_sram_req   = 1'b0;
        data_sram_req   = 1'b1;
        data_sram_wr    = 1'b1;
        data_sram_size  = 2'b01;
        data_sram_wstrb = 4'h3;
        data_sram_addr  = 32'h00003000;
        data_sram_wdata = 32'h0000ABCD;
        out_data_ok     = 1'b1;
        #1;
        nvec++;
        if (data_sram_addr_ok !== 1'b1 || out_size !== 2'b01 || out_wstrb !== 4'h3) begin
            nerr++;
            $display("FAIL ord_acc1: got ok=%b size=%b wstrb=%h want 1 01 3",
                     data_sram_addr_ok, out_size, out_wstrb);
        end
        nvec++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL ord_resp0: got %b%b want 10", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        data_sram_req  = 1'b0;
        data_sram_wr   = 1'b0;
        inst_sram_req  = 1'b1;
        inst_sram_addr = 32'hBFC00204;
        #1;
        nvec++;
        if (inst_sram_addr_ok !== 1'b1) begin
            nerr++;
            $display("FAIL ord_acc2: got %b want 1", inst_sram_addr_ok);
        end
        nvec++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b1) begin
            nerr++;
            $display("FAIL ord_resp1: got %b%b want 01", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        inst_sram_req = 1'b0;
        out_addr_ok   = 1'b0;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b1 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL ord_resp2: got %b%b want 10", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        inst_sram_req = 1'b1;
        out_addr_ok   = 1'b1;
        repeat (3) step();
        idle();
        out_data_ok = 1'b1;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b1) begin
            nerr++;
            $display("FAIL arst_pre: got %b want 1", inst_sram_data_ok);
        end
        reset = 1'b1;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL arst_during: got %b%b want 00", inst_sram_data_ok, data_sram_data_ok);
        end
        reset = 1'b0;
        #1;
        nvec++;
        if (inst_sram_data_ok !== 1'b0 || data_sram_data_ok !== 1'b0) begin
            nerr++;
            $display("FAIL arst_stray: got %b%b want 00", inst_sram_data_ok, data_sram_data_ok);
        end
        step();
        out_data_ok   = 1'b0;
        inst_sram_req = 1'b1;
        out_addr_ok   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nvec++;
            if (inst_sram_addr_ok !== 1'b1) begin
                nerr++;
                $display("FAIL arst_refill%0d: got %b want 1", i, inst_sram_addr_ok);
            end
            step();
        end
        #1;
        nvec++;
        if (out_req !== 1'b0) begin
            nerr++;
            $display("FAIL arst_full: got %b want 0", out_req);
        end
        idle();
        step();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_fetch();
        test_contention();
        test_lock();
        test_full();
        test_ordering();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
